// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// The optional per-requester weighting is enabled by WRR_ARBITER_WEIGHT_EN.
package wrr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 10;
  localparam int DEF_WEIGHT_W = 4;
  localparam int MAX_WEIGHT_W = 16;

  // A zero weight still grants one transfer so a requester can never starve itself.
  function automatic logic [MAX_WEIGHT_W-1:0] clamp_weight(input logic [MAX_WEIGHT_W-1:0] w);
    logic [MAX_WEIGHT_W-1:0] r;
    if (w == 16'd0) begin
      r = 16'd1;
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rot_prio_pick.sv
// Combinational rotating fixed-priority picker: the lowest requesting index
// at or after ptr wins, wrapping from NUM_REQ-1 back to 0.
module rot_prio_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDX_W'(s);
  endfunction

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan candidates in priority order and keep the first one that requests.
  always_comb begin
    onehot = {NUM_REQ{1'b0}};
    idx    = {IDX_W{1'b0}};
    any    = 1'b0;
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = wrap_add(ptr, i);
      hit_s  = ~any & req[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
    if (any) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with multi-beat grant hold and registered grants.
// Define WRR_ARBITER_WEIGHT_EN to honour per-requester weights; otherwise plain round-robin.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  input  logic                         gnt_ready,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         gnt_valid,
  output logic [IDX_W-1:0]             gnt_idx
);

  arb_state_t         state_r, state_nxt_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0]   owner_r, owner_nxt_s, owner_inc_s;
  logic [IDX_W-1:0]   pick_ptr_s, pick_idx_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic               pick_any_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
  logic               gnt_valid_r, gnt_valid_nxt_s;
  logic               busy_s, owner_req_s, xfer_end_s;
  logic               keep_s, load_s, dec_s;

  assign busy_s      = (state_r == BUSY);
  assign owner_req_s = req[owner_r];
  assign xfer_end_s  = busy_s & owner_req_s & gnt_ready & req_last[owner_r];
  assign owner_inc_s = (owner_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : owner_r + IDX_W'(1);
  // While busy the picker only matters on release, where the releasing owner becomes lowest priority.
  assign pick_ptr_s  = busy_s ? owner_inc_s : ptr_r;

  rot_prio_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr_s),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

`ifdef WRR_ARBITER_WEIGHT_EN
  logic [WEIGHT_W-1:0] credit_r;
  logic [WEIGHT_W-1:0] credit_load_s;
  logic [WEIGHT_W-1:0] weight_arr_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
    assign weight_arr_s[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
  end

  assign credit_load_s = WEIGHT_W'(clamp_weight(MAX_WEIGHT_W'(weight_arr_s[pick_idx_s])));
  assign keep_s        = (credit_r > WEIGHT_W'(1));

  // Credit counter: loaded at each grant, decremented on each completed transfer that keeps the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= WEIGHT_W'(0);
    end else if (load_s) begin
      credit_r <= credit_load_s;
    end else if (dec_s) begin
      credit_r <= credit_r - WEIGHT_W'(1);
    end else begin
      credit_r <= credit_r;
    end
  end
`else
  logic unused_weight_s;
  assign unused_weight_s = ^{weight, dec_s};
  assign keep_s          = 1'b0;
`endif

  // Next-state logic: grant from idle, hold across transfers, release with same-cycle regrant.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    load_s      = 1'b0;
    dec_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = BUSY;
          owner_nxt_s = pick_idx_s;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (!owner_req_s || (xfer_end_s && !keep_s)) begin
          ptr_nxt_s = owner_inc_s;
          if (pick_any_s) begin
            owner_nxt_s = pick_idx_s;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (xfer_end_s) begin
          dec_s = 1'b1;
        end else begin
          dec_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output look-ahead so gnt and gnt_valid are registered yet track the new owner without a bubble.
  always_comb begin
    gnt_nxt_s       = {NUM_REQ{1'b0}};
    gnt_valid_nxt_s = (state_nxt_s == BUSY) & req[owner_nxt_s];
    if (load_s) begin
      gnt_nxt_s = pick_onehot_s;
    end else if (state_nxt_s == BUSY) begin
      gnt_nxt_s = gnt_r;
    end else begin
      gnt_nxt_s = {NUM_REQ{1'b0}};
    end
  end

  // State, pointer, owner and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      owner_r     <= {IDX_W{1'b0}};
      gnt_r       <= {NUM_REQ{1'b0}};
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      owner_r     <= owner_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_idx   = owner_r;

endmodule
